fp_mul_exception_unit: RTL and testbench

//  Parametrised IEEE-754 exception/special-case unit for the FP multiplier.
//  - Classifies operands on input; carries the class through a PIPE_DEPTH delay line matched to datapath latency.
//  - Combines the class with the datapath result to raise per-operation flags and a forced special result.
//  - Keeps sticky status bits. Supports half/single/double via widths; replaces the fixed single-precision checker.

---
 rtl/fp_mul_exception_unit.sv | 137 +++++++++++++
 tb/tb_fp_mul_exception_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_exception_unit.sv
// IEEE-754 special-case unit for the FP multiplier: classifies operands, carries the class
// alongside the datapath, then raises flags and a forced result when the datapath result arrives.
module fp_mul_exception_unit #(
  parameter int EXP_W           = 8,
  parameter int MAN_W           = 23,
  parameter int PIPE_DEPTH      = 7,
  parameter bit NAN_INVALID_ALL = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  input  logic                     Sx,
  input  logic                     Sy,
  input  logic [EXP_W-1:0]         Ex,
  input  logic [EXP_W-1:0]         Ey,
  input  logic [MAN_W-1:0]         Mx,
  input  logic [MAN_W-1:0]         My,
  input  logic                     res_valid,
  input  logic [EXP_W-1:0]         Ez,
  input  logic [MAN_W:0]           Mz,
  input  logic                     overflow_case,
  input  logic                     clear_sticky,
  output logic                     out_valid,
  output logic                     invalid_flag,
  output logic                     overflow_flag,
  output logic                     zero_flag,
  output logic                     underflow_flag,
  output logic                     special_valid,
  output logic [EXP_W+MAN_W:0]     special_result,
  output logic [3:0]               sticky_flags,
  output logic                     align_err
);

  localparam int RES_W = 1 + EXP_W + MAN_W;
  localparam logic [RES_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic valid;
    logic sign;
    logic zero_x;
    logic inf_x;
    logic nan_x;
    logic snan_x;
    logic zero_y;
    logic inf_y;
    logic nan_y;
    logic snan_y;
  } entry_t;

  entry_t head;
  entry_t tail;
  entry_t line_q [PIPE_DEPTH];

  // Subnormal operands are flushed, so any zero exponent classifies as zero.
  always_comb begin
    head        = '0;
    head.valid  = in_valid;
    head.sign   = Sx ^ Sy;
    head.zero_x = (Ex == '0);
    head.inf_x  = (&Ex) && (Mx == '0);
    head.nan_x  = (&Ex) && (Mx != '0);
    head.snan_x = (&Ex) && (Mx != '0) && !Mx[MAN_W-1];
    head.zero_y = (Ey == '0);
    head.inf_y  = (&Ey) && (My == '0);
    head.nan_y  = (&Ey) && (My != '0);
    head.snan_y = (&Ey) && (My != '0) && !My[MAN_W-1];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < PIPE_DEPTH; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= head;
      for (int i = 1; i < PIPE_DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign tail = line_q[PIPE_DEPTH-1];

  logic             nan_op;
  logic             inv_d;
  logic             ovf_d;
  logic             zero_d;
  logic             unf_d;
  logic             any_d;
  logic             fire;
  logic             mismatch;
  logic [RES_W-1:0] sr_d;

  always_comb begin
    nan_op = tail.nan_x | tail.nan_y;
    inv_d  = (tail.zero_x & tail.inf_y) | (tail.inf_x & tail.zero_y) |
             (NAN_INVALID_ALL ? nan_op : (tail.snan_x | tail.snan_y));
    ovf_d  = !nan_op && !inv_d &&
             (tail.inf_x || tail.inf_y || ((&Ez) && (Mz[MAN_W-1:0] == '0)) || overflow_case);
    zero_d = !nan_op && !inv_d && (tail.zero_x || tail.zero_y);
    unf_d  = !nan_op && !inv_d && !ovf_d && !zero_d && (Ez == '0) && (Mz != '0);
    any_d  = inv_d | ovf_d | zero_d | unf_d;
    if (nan_op || inv_d) begin
      sr_d = QNAN;
    end else if (ovf_d) begin
      sr_d = {tail.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      sr_d = {tail.sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  assign fire     = tail.valid & res_valid;
  assign mismatch = tail.valid ^ res_valid;

  // A quiet NaN raises no flag when invalid is sNaN-only, yet still drives the canonical NaN out.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid      <= 1'b0;
      invalid_flag   <= 1'b0;
      overflow_flag  <= 1'b0;
      zero_flag      <= 1'b0;
      underflow_flag <= 1'b0;
      special_valid  <= 1'b0;
      special_result <= '0;
      sticky_flags   <= 4'b0;
      align_err      <= 1'b0;
    end else begin
      out_valid      <= fire;
      invalid_flag   <= fire & inv_d;
      overflow_flag  <= fire & ovf_d;
      zero_flag      <= fire & zero_d;
      underflow_flag <= fire & unf_d;
      special_valid  <= fire & any_d;
      if (fire && (any_d || nan_op)) special_result <= sr_d;
      sticky_flags   <= (clear_sticky ? 4'b0 : sticky_flags) |
                        ({inv_d, ovf_d, unf_d, zero_d} & {4{fire}});
      align_err      <= (clear_sticky ? 1'b0 : align_err) | mismatch;
    end
  end

endmodule

// File: tb/tb_fp_mul_exception_unit.sv
// Bench for fp_mul_exception_unit: two single-precision units (both NaN policies) and one
// double-precision unit, driven as the multiplier datapath would, checked by a scoreboard.
module tb_fp_mul_exception_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_iv, a_rv, a_ovc, a_clr;
  logic [31:0] a_x, a_y;
  logic [7:0]  a_ez;
  logic [23:0] a_mz;
  logic        b_iv, b_rv, b_ovc, b_clr;
  logic [63:0] b_x, b_y;
  logic [10:0] b_ez;
  logic [52:0] b_mz;

  logic [2:0]  ov, inv, ovf, zf, uf, sv, ae;
  logic [31:0] sr0, sr1;
  logic [63:0] sr2;
  logic [3:0]  st0, st1, st2;

  fp_mul_exception_unit #(.EXP_W(8), .MAN_W(23), .PIPE_DEPTH(7), .NAN_INVALID_ALL(1'b1)) u0 (
    .CLK(clk), .RST(rst_n), .in_valid(a_iv), .Sx(a_x[31]), .Sy(a_y[31]),
    .Ex(a_x[30:23]), .Ey(a_y[30:23]), .Mx(a_x[22:0]), .My(a_y[22:0]),
    .res_valid(a_rv), .Ez(a_ez), .Mz(a_mz), .overflow_case(a_ovc), .clear_sticky(a_clr),
    .out_valid(ov[0]), .invalid_flag(inv[0]), .overflow_flag(ovf[0]), .zero_flag(zf[0]),
    .underflow_flag(uf[0]), .special_valid(sv[0]), .special_result(sr0),
    .sticky_flags(st0), .align_err(ae[0]));

  fp_mul_exception_unit #(.EXP_W(8), .MAN_W(23), .PIPE_DEPTH(7), .NAN_INVALID_ALL(1'b0)) u1 (
    .CLK(clk), .RST(rst_n), .in_valid(a_iv), .Sx(a_x[31]), .Sy(a_y[31]),
    .Ex(a_x[30:23]), .Ey(a_y[30:23]), .Mx(a_x[22:0]), .My(a_y[22:0]),
    .res_valid(a_rv), .Ez(a_ez), .Mz(a_mz), .overflow_case(a_ovc), .clear_sticky(a_clr),
    .out_valid(ov[1]), .invalid_flag(inv[1]), .overflow_flag(ovf[1]), .zero_flag(zf[1]),
    .underflow_flag(uf[1]), .special_valid(sv[1]), .special_result(sr1),
    .sticky_flags(st1), .align_err(ae[1]));

  fp_mul_exception_unit #(.EXP_W(11), .MAN_W(52), .PIPE_DEPTH(3), .NAN_INVALID_ALL(1'b0)) u2 (
    .CLK(clk), .RST(rst_n), .in_valid(b_iv), .Sx(b_x[63]), .Sy(b_y[63]),
    .Ex(b_x[62:52]), .Ey(b_y[62:52]), .Mx(b_x[51:0]), .My(b_y[51:0]),
    .res_valid(b_rv), .Ez(b_ez), .Mz(b_mz), .overflow_case(b_ovc), .clear_sticky(b_clr),
    .out_valid(ov[2]), .invalid_flag(inv[2]), .overflow_flag(ovf[2]), .zero_flag(zf[2]),
    .underflow_flag(uf[2]), .special_valid(sv[2]), .special_result(sr2),
    .sticky_flags(st2), .align_err(ae[2]));

  typedef struct packed {
    logic        v;
    logic        rv;
    logic        ovc;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] ez;
    logic [63:0] mz;
  } op_t;

  typedef struct packed {
    logic        ov;
    logic [3:0]  fl;
    logic        sv;
    logic        chk_sr;
    logic [63:0] sr;
    logic [3:0]  st;
    logic        ae;
  } sb_t;

  typedef enum {K_ZERO, K_FIN, K_INF, K_QNAN, K_SNAN} kind_t;

  op_t  pa[$], pb[$];
  sb_t  eq0[$], eq1[$], eq2[$];
  logic [3:0] st_m [3];
  logic       ae_m [3];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  localparam op_t IDLE = '0;

  task automatic cmp(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", nm, i, $time, act, exp_v);
    end
  endtask

  function automatic kind_t kind_of(input int ew, input int mw, input logic [63:0] x);
    logic [63:0] emask, fmask, e, f;
    emask = (64'd1 << ew) - 1;
    fmask = (64'd1 << mw) - 1;
    e = (x >> mw) & emask;
    f = x & fmask;
    if (e == 0) return K_ZERO;
    if (e != emask) return K_FIN;
    if (f == 0) return K_INF;
    return ((f >> (mw - 1)) & 64'd1) != 0 ? K_QNAN : K_SNAN;
  endfunction

  // Reference: decide each operand's IEEE kind, then apply the multiply exception rules.
  function automatic sb_t ref_model(input int ew, input int mw, input bit nan_all, input op_t r,
                                    input logic clr, input logic [3:0] st_prev, input logic ae_prev);
    sb_t e;
    kind_t kx, ky;
    logic [63:0] emask, fmask, s, ez, mz;
    bit fire, mis, nanop, inv, ovf, zro, unf;
    e = '0;
    emask = (64'd1 << ew) - 1;
    fmask = (64'd1 << mw) - 1;
    fire = r.v && r.rv;
    mis = r.v != r.rv;
    kx = kind_of(ew, mw, r.x);
    ky = kind_of(ew, mw, r.y);
    s = ((r.x ^ r.y) >> (ew + mw)) & 64'd1;
    ez = r.ez & emask;
    mz = r.mz & ((64'd1 << (mw + 1)) - 1);
    nanop = (kx == K_QNAN) || (kx == K_SNAN) || (ky == K_QNAN) || (ky == K_SNAN);
    inv = (kx == K_ZERO && ky == K_INF) || (kx == K_INF && ky == K_ZERO) ||
          (nan_all ? nanop : (kx == K_SNAN || ky == K_SNAN));
    ovf = !nanop && !inv && (kx == K_INF || ky == K_INF || (ez == emask && (mz & fmask) == 0) || r.ovc);
    zro = !nanop && !inv && (kx == K_ZERO || ky == K_ZERO);
    unf = !nanop && !inv && !ovf && !zro && ez == 0 && mz != 0;
    if (fire) begin
      e.ov = 1'b1;
      e.fl = {inv, ovf, unf, zro};
      e.sv = inv || ovf || unf || zro;
      e.chk_sr = e.sv || nanop;
      if (nanop || inv) e.sr = (emask << mw) | (64'd1 << (mw - 1));
      else if (ovf) e.sr = (s << (ew + mw)) | (emask << mw);
      else e.sr = s << (ew + mw);
    end
    e.st = (clr ? 4'b0 : st_prev) | e.fl;
    e.ae = (clr ? 1'b0 : ae_prev) | mis;
    return e;
  endfunction

  task automatic cycle(input op_t oa, input logic clra, input op_t ob, input logic clrb);
    op_t ra, rb;
    sb_t e;
    @(negedge clk);
    a_iv = oa.v; a_x = oa.x[31:0]; a_y = oa.y[31:0]; a_clr = clra;
    pa.push_back(oa);
    ra = '0;
    if (pa.size() > 7) ra = pa.pop_front();
    a_rv = ra.rv; a_ez = ra.ez[7:0]; a_mz = ra.mz[23:0]; a_ovc = ra.ovc;
    e = ref_model(8, 23, 1'b1, ra, clra, st_m[0], ae_m[0]);
    st_m[0] = e.st; ae_m[0] = e.ae; eq0.push_back(e);
    e = ref_model(8, 23, 1'b0, ra, clra, st_m[1], ae_m[1]);
    st_m[1] = e.st; ae_m[1] = e.ae; eq1.push_back(e);
    b_iv = ob.v; b_x = ob.x; b_y = ob.y; b_clr = clrb;
    pb.push_back(ob);
    rb = '0;
    if (pb.size() > 3) rb = pb.pop_front();
    b_rv = rb.rv; b_ez = rb.ez[10:0]; b_mz = rb.mz[52:0]; b_ovc = rb.ovc;
    e = ref_model(11, 52, 1'b0, rb, clrb, st_m[2], ae_m[2]);
    st_m[2] = e.st; ae_m[2] = e.ae; eq2.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic ca(input op_t o, input logic clr);
    cycle(o, clr, IDLE, 1'b0);
  endtask

  task automatic cb(input op_t o, input logic clr);
    cycle(IDLE, 1'b0, o, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(IDLE, 1'b0, IDLE, 1'b0);
  endtask

  function automatic op_t mk(input logic [63:0] x, input logic [63:0] y, input logic [63:0] ez,
                             input logic [63:0] mz, input logic ovc);
    op_t o;
    o = '0;
    o.v = 1'b1; o.rv = 1'b1; o.x = x; o.y = y; o.ez = ez; o.mz = mz; o.ovc = ovc;
    return o;
  endfunction

  function automatic logic [63:0] rnd_opnd(input int ew, input int mw);
    logic [63:0] s, e, f, emask, fmask;
    emask = (64'd1 << ew) - 1;
    fmask = (64'd1 << mw) - 1;
    s = 64'($urandom_range(0, 1));
    f = {$urandom, $urandom} & fmask;
    case ($urandom_range(0, 9))
      0: begin e = 0; f = 0; end
      1: e = 0;
      2: begin e = emask; f = 0; end
      3: begin e = emask; f = f | (64'd1 << (mw - 1)); end
      4: begin
        e = emask;
        f = f & ~(64'd1 << (mw - 1));
        if (f == 0) f = 64'd1;
      end
      default: e = 64'($urandom_range(1, (1 << ew) - 2));
    endcase
    return (s << (ew + mw)) | (e << mw) | f;
  endfunction

  function automatic op_t rnd_op(input int ew, input int mw);
    op_t o;
    logic [63:0] emask;
    emask = (64'd1 << ew) - 1;
    o = '0;
    o.v = ($urandom_range(0, 3) != 0);
    o.rv = o.v;
    if ($urandom_range(0, 29) == 0) o.rv = !o.v;
    o.x = rnd_opnd(ew, mw);
    o.y = rnd_opnd(ew, mw);
    case ($urandom_range(0, 3))
      0: o.ez = 0;
      1: o.ez = emask;
      default: o.ez = 64'($urandom_range(0, (1 << ew) - 1));
    endcase
    case ($urandom_range(0, 3))
      0: o.mz = 0;
      1: o.mz = 64'd1 << mw;
      default: o.mz = {$urandom, $urandom} & ((64'd1 << (mw + 1)) - 1);
    endcase
    o.ovc = ($urandom_range(0, 7) == 0);
    return o;
  endfunction

  task automatic check(input int i, input logic a_ov, input logic [3:0] a_fl, input logic a_sv,
                       input logic [63:0] a_sr, input logic [3:0] a_st, input logic a_ae);
    sb_t e;
    int n;
    n = (i == 0) ? eq0.size() : (i == 1) ? eq1.size() : eq2.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underrun dut%0d t=%0t got=empty expected=entry", i, $time);
      return;
    end
    case (i)
      0: e = eq0.pop_front();
      1: e = eq1.pop_front();
      default: e = eq2.pop_front();
    endcase
    cmp("out_valid", i, 64'(a_ov), 64'(e.ov));
    cmp("flags", i, 64'(a_fl), 64'(e.fl));
    cmp("special_valid", i, 64'(a_sv), 64'(e.sv));
    if (e.chk_sr) cmp("special_result", i, a_sr, e.sr);
    cmp("sticky_flags", i, 64'(a_st), 64'(e.st));
    cmp("align_err", i, 64'(a_ae), 64'(e.ae));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        check(0, ov[0], {inv[0], ovf[0], uf[0], zf[0]}, sv[0], {32'd0, sr0}, st0, ae[0]);
        check(1, ov[1], {inv[1], ovf[1], uf[1], zf[1]}, sv[1], {32'd0, sr1}, st1, ae[1]);
        check(2, ov[2], {inv[2], ovf[2], uf[2], zf[2]}, sv[2], sr2, st2, ae[2]);
      end
    end
  end

  task automatic drive_zero();
    a_iv = 0; a_rv = 0; a_ovc = 0; a_clr = 0; a_x = 0; a_y = 0; a_ez = 0; a_mz = 0;
    b_iv = 0; b_rv = 0; b_ovc = 0; b_clr = 0; b_x = 0; b_y = 0; b_ez = 0; b_mz = 0;
  endtask

  task automatic reset_check();
    cmp("rst_ctrl_outs", 0, 64'({ov, inv, ovf, zf, uf, sv, ae}), 64'd0);
    cmp("rst_special_result", 0, {sr0, sr1}, 64'd0);
    cmp("rst_special_result", 2, sr2, 64'd0);
    cmp("rst_sticky", 0, 64'({st0, st1, st2}), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mon_en = 1'b0;
    drive_zero();
    pa.delete(); pb.delete(); eq0.delete(); eq1.delete(); eq2.delete();
    for (int i = 0; i < 3; i++) begin st_m[i] = 4'b0; ae_m[i] = 1'b0; end
    #1;
    reset_check();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=no_finish expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    logic clr;
    rst_n = 1'b0;
    drive_zero();
    for (int i = 0; i < 3; i++) begin st_m[i] = 4'b0; ae_m[i] = 1'b0; end
    repeat (2) @(negedge clk);
    reset_check();
    rst_n = 1'b1;

    // single precision directed cases
    ca(mk(64'h3F800000, 64'h40000000, 64'h80, 64'h800000, 1'b0), 1'b0);
    ca(mk(64'h00000000, 64'h7F800000, 64'h80, 64'h800000, 1'b0), 1'b0);
    ca(mk(64'h7FC00001, 64'h3F800000, 64'h80, 64'h800000, 1'b0), 1'b0);
    ca(mk(64'hFF800000, 64'h40000000, 64'h80, 64'h800000, 1'b0), 1'b0);
    ca(mk(64'h3F800000, 64'h40000000, 64'h80, 64'h800000, 1'b1), 1'b0);
    ca(mk(64'hBF800000, 64'h40000000, 64'h00, 64'h400000, 1'b0), 1'b0);
    ca(mk(64'h3F800000, 64'h40000000, 64'hFF, 64'h800000, 1'b0), 1'b0);
    ca(mk(64'h00000000, 64'h3F800000, 64'h80, 64'h800000, 1'b0), 1'b0);
    idle(6);
    ca(IDLE, 1'b1);
    @(posedge clk);
    #2;
    cmp("sticky_clear_with_zero", 0, 64'(st0), 64'h1);

    o = mk(64'h3F800000, 64'h40000000, 64'h80, 64'h800000, 1'b0);
    o.rv = 1'b0;
    ca(o, 1'b0);
    idle(9);
    ca(mk(64'h3F800000, 64'h40000000, 64'h80, 64'h800000, 1'b0), 1'b0);
    idle(2);
    do_reset();
    idle(10);

    // double precision, depth 3
    cb(mk(64'h3FF0000000000000, 64'h4000000000000000, 64'h400, 64'h10000000000000, 1'b0), 1'b0);
    cb(mk(64'h0, 64'h7FF0000000000000, 64'h400, 64'h10000000000000, 1'b0), 1'b0);
    cb(mk(64'h7FF8000000000001, 64'h3FF0000000000000, 64'h400, 64'h10000000000000, 1'b0), 1'b0);
    cb(mk(64'hFFF0000000000000, 64'h4000000000000000, 64'h400, 64'h10000000000000, 1'b0), 1'b0);
    cb(mk(64'h3FF0000000000000, 64'h4000000000000000, 64'h400, 64'h10000000000000, 1'b1), 1'b0);
    idle(5);

    for (int i = 0; i < 40; i++) begin
      o = rnd_op(8, 23);
      o.v = 1'b1; o.rv = 1'b1;
      cycle(o, 1'b0, rnd_op(11, 52), 1'b0);
    end
    for (int i = 0; i < 600; i++) begin
      clr = ($urandom_range(0, 19) == 0);
      cycle(rnd_op(8, 23), clr, rnd_op(11, 52), clr);
    end
    idle(10);
    @(posedge clk);
    #2;
    cmp("scoreboard_drained", 0, 64'(eq0.size() + eq1.size() + eq2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
